// File: rtl/tile_deal_controller.sv
// ----------------------------------------------------------------------------
// tile_deal_controller : builds, shuffles and streams a paired tile board
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tile_deal_controller #(
  parameter int          NUM_TILES = 10,
  parameter int          CODE_W    = 11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              CLOCK_50,
  input  logic              clear,
  input  logic              start,
  input  logic              abort,
  input  logic              seed_load,
  input  logic [15:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              tile_we,
  output logic [3:0]        tile_addr,
  output logic [CODE_W-1:0] tile_code,
  output logic [7:0]        deal_count
);

  localparam logic [3:0] LAST = 4'(NUM_TILES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SHUFFLE = 3'd2,
    EMIT    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  idx, idx_nx;
  logic [15:0] lfsr, lfsr_step;
  logic [3:0]  colour [NUM_TILES];
  logic [3:0]  cand;
  logic        accept;
  logic        abort_ok;

  // Galois form of x^16+x^14+x^13+x^11; never reaches zero from a non-zero state
  assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign cand      = lfsr[3:0];
  assign accept    = (cand <= idx);
  assign abort_ok  = abort && (state == INIT || state == SHUFFLE || state == EMIT);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge CLOCK_50 or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
      idx   <= 4'd0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        // a seed load in the same cycle takes priority over start
        if (start && !seed_load) begin
          state_nx = INIT;
          idx_nx   = 4'd0;
        end
      end
      INIT: begin
        if (idx == LAST) begin
          state_nx = SHUFFLE;
          idx_nx   = LAST;
        end else begin
          idx_nx = idx + 4'd1;
        end
      end
      SHUFFLE: begin
        if (accept) begin
          if (idx == 4'd1) begin
            state_nx = EMIT;
            idx_nx   = 4'd0;
          end else begin
            idx_nx = idx - 4'd1;
          end
        end
      end
      EMIT: begin
        if (idx == LAST) state_nx = DONE;
        else             idx_nx   = idx + 4'd1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort_ok) begin
      state_nx = IDLE;
      idx_nx   = 4'd0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge clear) begin
    if (!clear) begin
      lfsr       <= LFSR_SEED;
      tile_we    <= 1'b0;
      tile_addr  <= 4'd0;
      tile_code  <= '0;
      deal_count <= 8'd0;
      for (int k = 0; k < NUM_TILES; k++) colour[k] <= 4'd0;
    end else begin
      if (state == IDLE && seed_load) lfsr <= (seed == 16'h0000) ? LFSR_SEED : seed;
      else                            lfsr <= lfsr_step;

      tile_we <= 1'b0;
      if (state == EMIT && !abort) begin
        tile_we   <= 1'b1;
        tile_addr <= idx;
        tile_code <= CODE_W'({idx[3:2], idx[1:0], 2'b00, colour[idx], 1'b0});
      end

      if (state == INIT && !abort) colour[idx] <= 4'((idx >> 1) + 4'd1);

      if (state == SHUFFLE && !abort && accept) begin
        colour[idx]  <= colour[cand];
        colour[cand] <= colour[idx];
      end

      if (state == DONE) deal_count <= deal_count + 8'd1;
    end
  end

endmodule

`default_nettype wire
